// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: state encoding and counter sizing shared by the sequential multiplier.
package mult_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/mult_seq_add_bits.sv
// ADD_BITS: plain W-bit adder shared by accumulation and final negation.
module ADD_BITS #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);
    assign sum = a + b + W'(cin);
endmodule

// File: rtl/mult_seq.sv
// mult_seq: shift-and-add multiplier, one multiplier bit per cycle, sign applied at the end.
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int BITS      = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [BITS-1:0] _A,
    input  logic [BITS-1:0] _B,
    input  logic            SIGNED_,
    input  logic            IN_VALID,
    output logic            IN_READY,
    output logic [2*BITS-1:0] OUT_,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic            BUSY
);
    localparam int PW = 2 * BITS;
    localparam int CW = clog2(BITS);

    state_e          state_q, state_d;
    logic [BITS-1:0] a_q, a_d, b_q, b_d;
    logic            sign_q, sign_d;
    logic [PW-1:0]   acc_q, acc_d, out_q, out_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   add_a, add_b, sum, res;
    logic            signed_op, last;

    ADD_BITS #(.W(PW)) u_add (.a(add_a), .b(add_b), .cin(1'b0), .sum(sum));

    // In DONE the adder computes ~acc + 1, so the negated product needs no second adder.
    always_comb begin
        signed_op = SIGNED_EN && SIGNED_;
        last      = (cnt_q == CW'(BITS - 1));
        add_a     = (state_q == DONE) ? ~acc_q : acc_q;
        add_b     = (state_q == DONE) ? PW'(1) : (b_q[cnt_q] ? (PW'(a_q) << cnt_q) : '0);
        res       = sign_q ? sum : acc_q;
        OUT_      = (state_q == DONE) ? res : out_q;
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        case (state_q)
            IDLE: if (IN_VALID) begin
                a_d     = (signed_op && _A[BITS-1]) ? -_A : _A;
                b_d     = (signed_op && _B[BITS-1]) ? -_B : _B;
                sign_d  = signed_op && (_A[BITS-1] ^ _B[BITS-1]);
                acc_d   = '0;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                acc_d   = sum;
                cnt_d   = cnt_q + CW'(1);
                state_d = last ? DONE : CALC;
            end
            DONE: if (OUT_READY) begin
                out_d   = res;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign BUSY      = (state_q != IDLE);
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: vector table and corner sequences on a 4-bit instance, unsigned-only and random 8-bit traffic.
module tb_mult_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0]  a4 = '0, b4 = '0;
    logic        s4 = 0, iv4 = 0, ir4, ov4, or4 = 0, busy4;
    logic [7:0]  o4;
    logic [7:0]  au = '0, bu = '0, a8 = '0, b8 = '0;
    logic        su = 0, ivu = 0, iru, ovu, oru = 0, busyu;
    logic        s8 = 0, iv8 = 0, ir8, ov8, or8 = 0, busy8;
    logic [15:0] ou, o8;

    logic [7:0]  q4[$];
    logic [15:0] q8[$];

    mult_seq #(.BITS(4), .SIGNED_EN(1'b1)) u4 (
        .CLK(clk), .RST_N(rst_n), ._A(a4), ._B(b4), .SIGNED_(s4), .IN_VALID(iv4),
        .IN_READY(ir4), .OUT_(o4), .OUT_VALID(ov4), .OUT_READY(or4), .BUSY(busy4));
    mult_seq #(.BITS(8), .SIGNED_EN(1'b0)) u8u (
        .CLK(clk), .RST_N(rst_n), ._A(au), ._B(bu), .SIGNED_(su), .IN_VALID(ivu),
        .IN_READY(iru), .OUT_(ou), .OUT_VALID(ovu), .OUT_READY(oru), .BUSY(busyu));
    mult_seq #(.BITS(8), .SIGNED_EN(1'b1)) u8 (
        .CLK(clk), .RST_N(rst_n), ._A(a8), ._B(b8), .SIGNED_(s8), .IN_VALID(iv8),
        .IN_READY(ir8), .OUT_(o8), .OUT_VALID(ov8), .OUT_READY(or8), .BUSY(busy8));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic signed [15:0] p;
        p = $signed(a) * $signed(b);
        return s ? p : (16'(a) * 16'(b));
    endfunction

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s, input logic [7:0] exp, input string nm);
        logic [7:0] e;
        a4 = a; b4 = b; s4 = s; iv4 = 1'b1;
        q4.push_back(exp);
        chk({nm, " ready"}, 64'(ir4), 64'(1));
        @(negedge clk);
        iv4 = 1'b0;
        repeat (3) @(negedge clk);
        chk({nm, " early"}, 64'(ov4), 64'(0));
        @(negedge clk);
        chk({nm, " valid"}, 64'(ov4), 64'(1));
        e = q4.pop_front();
        chk({nm, " out"}, 64'(o4), 64'(e));
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
        chk({nm, " idle"}, 64'(busy4), 64'(0));
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       s;
        logic [7:0] p;
    } vec_t;
    vec_t tv[10];

    initial begin
        logic [7:0] e4;
        int acc_cnt, out_cnt, cyc;
        logic acc, hs;
        tv[0] = '{4'hF, 4'hF, 1'b0, 8'hE1};
        tv[1] = '{4'h8, 4'h8, 1'b1, 8'h40};
        tv[2] = '{4'hF, 4'h7, 1'b1, 8'hF9};
        tv[3] = '{4'h0, 4'h9, 1'b0, 8'h00};
        tv[4] = '{4'h7, 4'h8, 1'b1, 8'hC8};
        tv[5] = '{4'h9, 4'h3, 1'b0, 8'h1B};
        tv[6] = '{4'h3, 4'h5, 1'b1, 8'h0F};
        tv[7] = '{4'h0, 4'h8, 1'b1, 8'h00};
        tv[8] = '{4'hF, 4'h1, 1'b0, 8'h0F};
        tv[9] = '{4'hF, 4'h1, 1'b1, 8'hFF};

        #12;
        chk("rst in_ready", 64'(ir4), 64'(1));
        chk("rst out_valid", 64'(ov4), 64'(0));
        chk("rst out", 64'(o4), 64'(0));
        chk("rst busy", 64'(busy4), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run4(tv[i].a, tv[i].b, tv[i].s, tv[i].p, $sformatf("vec%0d", i));

        // Backpressure: hold DONE for six cycles while poking IN_VALID.
        a4 = 4'h5; b4 = 4'h3; s4 = 1'b0; iv4 = 1'b1;
        q4.push_back(8'h0F);
        @(negedge clk);
        iv4 = 1'b0;
        repeat (4) @(negedge clk);
        e4 = q4.pop_front();
        for (int i = 0; i < 6; i++) begin
            chk("bp valid", 64'(ov4), 64'(1));
            chk("bp out", 64'(o4), 64'(e4));
            chk("bp in_ready", 64'(ir4), 64'(0));
            a4 = 4'h9; b4 = 4'h9; iv4 = i[0];
            @(negedge clk);
        end
        iv4 = 1'b1; or4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0; or4 = 1'b0;
        chk("bp no accept on leave", 64'(busy4), 64'(0));
        chk("bp valid low", 64'(ov4), 64'(0));
        chk("bp out held", 64'(o4), 64'(e4));

        // Reset after two CALC edges.
        a4 = 4'h7; b4 = 4'h7; s4 = 1'b0; iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 64'(busy4), 64'(0));
        chk("midrst valid", 64'(ov4), 64'(0));
        chk("midrst out", 64'(o4), 64'(0));
        chk("midrst in_ready", 64'(ir4), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        run4(4'h3, 4'h5, 1'b0, 8'h0F, "post-reset 3*5");

        // SIGNED_ ignored when signed mode is compiled out.
        au = 8'hFF; bu = 8'h02; su = 1'b1; ivu = 1'b1;
        @(negedge clk);
        ivu = 1'b0;
        for (int i = 0; i < 20 && !ovu; i++) @(negedge clk);
        chk("unsigned-only valid", 64'(ovu), 64'(1));
        chk("unsigned-only out", 64'(ou), 64'(16'h01FE));
        oru = 1'b1;
        @(negedge clk);
        oru = 1'b0;

        // Random back-to-back traffic with scoreboard.
        acc_cnt = 0; out_cnt = 0; cyc = 0;
        a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
        while (out_cnt < 1000 && cyc < 30000) begin
            iv8 = (acc_cnt < 1000);
            or8 = ($urandom_range(0, 3) != 0);
            acc = iv8 && ir8;
            hs  = ov8 && or8;
            if (hs) begin
                if (q8.size() == 0) chk("rnd spurious handshake", 64'(1), 64'(0));
                else chk($sformatf("rnd op%0d", out_cnt), 64'(o8), 64'(q8.pop_front()));
                out_cnt++;
            end
            if (acc) begin
                q8.push_back(ref8(a8, b8, s8));
                acc_cnt++;
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                a8 = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
                b8 = ($urandom_range(0, 7) == 0) ? 8'h80 : (($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
                s8 = 1'($urandom);
            end
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        chk("rnd accepts", 64'(acc_cnt), 64'(1000));
        chk("rnd outputs", 64'(out_cnt), 64'(1000));
        chk("rnd queue empty", 64'(q8.size()), 64'(0));
        repeat (12) @(negedge clk);
        chk("rnd no extra valid", 64'(ov8), 64'(0));
        chk("rnd idle", 64'(busy8), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have parameter BITS, default 8, giving the operand width; legal range 2..32.
REQ-002 SHALL have parameter SIGNED_EN, default 1; 1 enables the per-operation signed mode and 0 ties the mode to unsigned.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock, rising-edge active.
REQ-005 SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port _A, input, BITS bits: multiplicand.
REQ-007 SHALL have port _B, input, BITS bits: multiplier.
REQ-008 SHALL have port SIGNED_, input, 1 bit: 1 means two's-complement operands, sampled with _A and _B.
REQ-009 SHALL have port IN_VALID, input, 1 bit: operands valid.
REQ-010 SHALL have port IN_READY, output, 1 bit: block can accept operands.
REQ-011 SHALL have port OUT_, output, 2*BITS bits: product.
REQ-012 SHALL have port OUT_VALID, output, 1 bit: OUT_ valid.
REQ-013 SHALL have port OUT_READY, input, 1 bit: consumer takes the product.
REQ-014 SHALL have port BUSY, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 SHALL implement the states IDLE, CALC and DONE.
REQ-016 SHALL define accept as a rising CLK edge with IN_VALID=1 and IN_READY=1; IN_READY SHALL be 1 only in IDLE.
REQ-017 SHALL do the following on accept: latch magnitude(_A) and magnitude(_B), latch sign = SIGNED_ & (_A[MSB] ^ _B[MSB]), clear the accumulator and counter, and move to CALC.
REQ-018 SHALL take magnitude(x) as x when unsigned, and as |x| in BITS-bit unsigned form when signed; -2^(BITS-1) maps to 2^(BITS-1).
REQ-019 SHALL process one multiplier bit per cycle in CALC, LSB first.
REQ-020 SHALL, on each CALC cycle, add the multiplicand shifted left by the counter value into the accumulator when the current multiplier bit is 1, and then increment the counter.
REQ-021 SHALL stay in CALC for exactly BITS edges, counting 0..BITS-1, and then enter DONE; OUT_VALID therefore rises on the BITS+1th edge after accept.
REQ-022 SHALL drive OUT_ in DONE as the accumulator when sign=0 and as its two's-complement negation over 2*BITS bits when sign=1.
REQ-023 SHALL keep OUT_ and OUT_VALID stable in DONE until an edge with OUT_READY=1, which moves the block to IDLE.
REQ-024 SHALL hold OUT_VALID=0 and OUT_ at its last value outside DONE.
REQ-025 SHALL ignore IN_VALID while in CALC or DONE; no operands are queued, and new operands SHALL NOT be accepted on the same edge that leaves DONE.
REQ-026 SHALL give a zero operand the full BITS-cycle latency, with no early termination.
REQ-027 SHALL ignore SIGNED_ and take the unsigned path when SIGNED_EN=0.
REQ-028 SHALL use accumulator width 2*BITS; no overflow is possible, including (-2^(BITS-1))^2.
REQ-029 SHALL keep the initiation interval at BITS+2 cycles minimum, counting accept, BITS CALC edges, and the DONE handshake.

Reset
REQ-030 SHALL, while RST_N=0, immediately force state=IDLE, OUT_=0, OUT_VALID=0, BUSY=0, and accumulator, counter and sign to 0.
REQ-031 SHALL drive IN_READY=1 during and after reset.
REQ-032 SHALL discard any operation in progress when reset is asserted in CALC or DONE, and SHALL NOT assert OUT_VALID for it after release.
REQ-033 SHALL allow an accept on the first rising edge after RST_N deasserts.

Structure
REQ-034 SHALL place the state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the counter width function clog2(BITS) in the shared multiplier package.
REQ-035 SHALL instantiate ADD_BITS with width 2*BITS as the single sub-module for the accumulate adder, carry-in 0.
REQ-036 SHALL reuse the same ADD_BITS instance for the final negation, adding ~acc to 1, selected by a mux in DONE; there SHALL be no second adder.
REQ-037 SHALL be synthesizable with no combinational path from any input to OUT_ or OUT_VALID.

Verification
REQ-038 SHALL be checked with BITS=4, unsigned: _A=15, _B=15 -> OUT_=8'hE1 with OUT_VALID on the 5th edge after accept.
REQ-039 SHALL be checked with BITS=4, signed: _A=-8, _B=-8 -> OUT_=8'h40; and _A=-1, _B=7 -> OUT_=8'hF9.
REQ-040 SHALL be checked for backpressure: OUT_READY held 0 for 6 cycles in DONE -> OUT_ and OUT_VALID stable and IN_READY=0 throughout; pulsing IN_VALID in that window SHALL NOT be accepted.
REQ-041 SHALL be checked for reset mid-CALC: RST_N=0 after 2 CALC edges -> outputs cleared asynchronously and no OUT_VALID after release; a next operation 3*5 -> 8'h0F.
REQ-042 SHALL be checked with BITS=8, SIGNED_EN=0: SIGNED_=1 with _A=8'hFF, _B=8'h02 -> OUT_=16'h01FE, treated as unsigned.
REQ-043 SHALL be checked with BITS=8 random back-to-back traffic, 1000 operations, mixed mode -> every OUT_ matches the reference product and there is exactly one OUT_VALID handshake per accept.
